gcd_dispatch: RTL and testbench

Operand dispatcher that sits directly upstream of the `gcd` engine. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It issues them one at a time to the engine with a one-cycle `start` pulse, waits for `done`, and returns each result, tagged, on a valid/ready output stream. Zero operands never reach the engine: the engine's subtract loop does not terminate on a zero operand, so the dispatcher resolves those pairs itself.

---
 rtl/gcd_dispatch.sv | 202 ++++++++++++++++++++
 tb/tb_gcd_dispatch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_dispatch.sv
// gcd_dispatch: buffers operand pairs, issues them one at a time to a gcd engine, returns tagged results.
// Define GCD_DISPATCH_TIMEOUT_EN to bound the engine wait and flag expired results on out_err.
module gcd_dispatch #(
   parameter int W       = 32,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   output logic [W-1:0]     gcd_a_in,
   output logic [W-1:0]     gcd_b_in,
   output logic             gcd_start,
   input  logic [W-1:0]     gcd_result,
   input  logic             gcd_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic             busy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = 2 * W + TAG_W;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   state_t           state_q, state_d;
   logic [W-1:0]     a_in_q, a_in_d, b_in_q, b_in_d, result_q, result_d;
   logic [TAG_W-1:0] otag_q, otag_d;
   logic             err_q, err_d, start_q, start_d, valid_q, valid_d, busy_q, busy_d;
   logic             push, pop, empty;
   logic [ENT_W-1:0] head;
   logic [W-1:0]     head_a, head_b;
   logic [TAG_W-1:0] head_tag;
`ifdef GCD_DISPATCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

   assign empty    = (count_q == '0);
   assign in_ready = (count_q != FULL_CNT);
   assign push     = in_valid && in_ready;
   assign pop      = (state_q == S_IDLE) && !empty;
   assign head     = mem_q[rd_ptr_q];
   assign head_a   = head[ENT_W-1 -: W];
   assign head_b   = head[TAG_W+W-1 -: W];
   assign head_tag = head[TAG_W-1:0];

   assign gcd_a_in   = a_in_q;
   assign gcd_b_in   = b_in_q;
   assign gcd_start  = start_q;
   assign out_valid  = valid_q;
   assign out_result = result_q;
   assign out_tag    = otag_q;
   assign out_err    = err_q;
   assign busy       = busy_q;

   // FIFO storage; the tag is attached at acceptance time
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_a, in_b, tag_q};
      end
   end

   // next-state, FIFO bookkeeping and output register inputs
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      tag_d    = tag_q;
      a_in_d   = a_in_q;
      b_in_d   = b_in_q;
      result_d = result_q;
      otag_d   = otag_q;
      err_d    = err_q;
`ifdef GCD_DISPATCH_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
`endif
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         tag_d    = tag_q + TAG_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
               otag_d   = head_tag;
               err_d    = 1'b0;
               // zero operands would hang the engine's subtract loop
               if ((head_a != '0) && (head_b != '0)) begin
                  a_in_d  = head_a;
                  b_in_d  = head_b;
                  state_d = S_ISSUE;
               end else begin
                  result_d = head_a | head_b;
                  state_d  = S_OUT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
`ifdef GCD_DISPATCH_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (gcd_done) begin
               result_d = gcd_result;
               err_d    = 1'b0;
               state_d  = S_OUT;
            end else begin
`ifdef GCD_DISPATCH_TIMEOUT_EN
               if (wait_cnt_q == WAIT_LIMIT) begin
                  result_d = '0;
                  err_d    = 1'b1;
                  state_d  = S_OUT;
               end else begin
                  wait_cnt_d = wait_cnt_q + CNT_W'(1);
               end
`else
               state_d = S_WAIT;
`endif
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_OUT;
            end
         end
         default: state_d = S_IDLE;
      endcase
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
      start_d = (state_d == S_ISSUE);
      valid_d = (state_d == S_OUT);
      busy_d  = (state_d != S_IDLE) || (count_d != '0);
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tag_q    <= '0;
         a_in_q   <= '0;
         b_in_q   <= '0;
         result_q <= '0;
         otag_q   <= '0;
         err_q    <= 1'b0;
         start_q  <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef GCD_DISPATCH_TIMEOUT_EN
         wait_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         tag_q    <= tag_d;
         a_in_q   <= a_in_d;
         b_in_q   <= b_in_d;
         result_q <= result_d;
         otag_q   <= otag_d;
         err_q    <= err_d;
         start_q  <= start_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
`ifdef GCD_DISPATCH_TIMEOUT_EN
         wait_cnt_q <= wait_cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_gcd_dispatch.sv
// Scoreboard bench for gcd_dispatch with a behavioural gcd engine model.
module tb_gcd_dispatch;
   localparam int W = 32, DEPTH = 4, TAG_W = 4, TIMEOUT = 16;

   logic clk = 1'b0, reset = 1'b1;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [W-1:0] in_a = '0, in_b = '0, gcd_a_in, gcd_b_in, out_result;
   logic [W-1:0] gcd_result = '0;
   logic gcd_done = 1'b0, gcd_start, out_err, busy;
   logic [TAG_W-1:0] out_tag;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  tag;
      logic        err;
   } exp_t;
   exp_t exp_q[$];
   int   vcyc[$];
   int   n_cmp = 0, n_bad = 0, cyc = 0, start_cnt = 0, last_done_cyc = -100;

   int          eng_lat = 10, eng_cnt = 0;
   logic        eng_en = 1'b1, eng_force = 1'b0;
   logic [31:0] eng_res = '0;

   gcd_dispatch #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .gcd_a_in(gcd_a_in), .gcd_b_in(gcd_b_in),
      .gcd_start(gcd_start), .gcd_result(gcd_result), .gcd_done(gcd_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x = a, y = b, t;
      for (int i = 0; i < 100 && y != 0; i++) begin
         t = x % y; x = y; y = t;
      end
      return x;
   endfunction

   // engine model: done pulses eng_lat cycles after start; not cleared by dispatcher reset
   always @(posedge clk) begin
      gcd_done <= 1'b0;
      if (gcd_start) begin
         eng_cnt <= eng_lat;
         eng_res <= ref_gcd(gcd_a_in, gcd_b_in);
      end else if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1 && eng_en) begin
            gcd_done   <= 1'b1;
            gcd_result <= eng_res;
         end
      end
      if (eng_force) begin
         gcd_done   <= 1'b1;
         gcd_result <= 32'hDEAD_BEEF;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // monitor: pops the scoreboard on every output handshake
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (gcd_start) start_cnt++;
         if (gcd_done) last_done_cyc = cyc;
         if (out_valid && out_ready) begin
            vcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_result: got tag %0d result %0d expected no output", out_tag, out_result);
            end else begin
               e = exp_q.pop_front();
               check("out_result", out_result, e.res);
               check("out_tag", 32'(out_tag), 32'(e.tag));
               check("out_err", 32'(out_err), 32'(e.err));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
      exp_q.delete(); vcyc.delete();
   endtask

   task automatic check_rst(input string p);
      check({p, "_in_ready"}, 32'(in_ready), 32'd1);
      check({p, "_gcd_start"}, 32'(gcd_start), 32'd0);
      check({p, "_gcd_a_in"}, gcd_a_in, 32'd0);
      check({p, "_gcd_b_in"}, gcd_b_in, 32'd0);
      check({p, "_out_valid"}, 32'(out_valid), 32'd0);
      check({p, "_out_result"}, out_result, 32'd0);
      check({p, "_out_tag"}, 32'(out_tag), 32'd0);
      check({p, "_out_err"}, 32'(out_err), 32'd0);
      check({p, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eres, input logic [3:0] etag, input logic eerr);
      exp_t e;
      bit   ok = 1'b0;
      e.res = eres; e.tag = etag; e.err = eerr;
      in_valid = 1'b1; in_a = a; in_b = b;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (in_ready) begin
            exp_q.push_back(e);
            ok = 1'b1;
         end
         tick();
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL push_timeout: got in_ready 0 for 200 cycles expected acceptance");
      end
   endtask

   task automatic wait_valid(input int maxc, output int at);
      at = -1;
      for (int i = 0; i < maxc; i++) begin
         if (out_valid) begin
            at = cyc;
            break;
         end
         tick();
      end
      if (at < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_valid_timeout: got no out_valid in %0d cycles expected one", maxc);
      end
   endtask

   task automatic drain(input int maxc);
      for (int i = 0; i < maxc && exp_q.size() != 0; i++) tick();
      check("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, at, s0, hits;

      do_reset();
      check_rst("reset");

      // engine path: (48,18) -> 6, start two cycles after the push
      eng_lat = 10; out_ready = 1'b1;
      push(32'd48, 32'd18, 32'd6, 4'd0, 1'b0);
      check("start_cycle1", 32'(gcd_start), 32'd0);
      tick();
      check("start_cycle2", 32'(gcd_start), 32'd1);
      check("gcd_a_in", gcd_a_in, 32'd48);
      check("gcd_b_in", gcd_b_in, 32'd18);
      wait_valid(60, at);
      check("valid_after_done", 32'(at), 32'(last_done_cyc + 1));
      drain(20);
      check("start_pulses", 32'(start_cnt), 32'd1);

      // bypass path: zero operands never reach the engine
      do_reset();
      s0 = start_cnt; out_ready = 1'b1;
      push(32'd0, 32'd35, 32'd35, 4'd0, 1'b0);
      c0 = cyc;
      push(32'd35, 32'd0, 32'd35, 4'd1, 1'b0);
      push(32'd0, 32'd0, 32'd0, 4'd2, 1'b0);
      drain(40);
      check("bypass_no_start", 32'(start_cnt), 32'(s0));
      check("bypass_count", 32'(vcyc.size()), 32'd3);
      if (vcyc.size() == 3) begin
         check("bypass_lat0", 32'(vcyc[0]), 32'(c0 + 1));
         check("bypass_lat1", 32'(vcyc[1]), 32'(c0 + 3));
         check("bypass_lat2", 32'(vcyc[2]), 32'(c0 + 5));
      end

      // backpressure: five pairs fill the FIFO plus the one in flight
      do_reset();
      out_ready = 1'b0; eng_lat = 3;
      push(32'd12, 32'd8, 32'd4, 4'd0, 1'b0);
      push(32'd21, 32'd14, 32'd7, 4'd1, 1'b0);
      push(32'd9, 32'd0, 32'd9, 4'd2, 1'b0);
      push(32'd100, 32'd75, 32'd25, 4'd3, 1'b0);
      check("ready_after4", 32'(in_ready), 32'd1);
      push(32'd17, 32'd5, 32'd1, 4'd4, 1'b0);
      check("ready_after5", 32'(in_ready), 32'd0);
      for (int i = 0; i < 20; i++) tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", out_result, 32'd4);
      check("stall_tag", 32'(out_tag), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      out_ready = 1'b1;
      drain(200);
      tick();
      check("idle_busy", 32'(busy), 32'd0);

      // tag counter wraps after 16 pairs
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 17; k++) push(32'd0, 32'(k + 1), 32'(k + 1), 4'(k), 1'b0);
      drain(200);

`ifdef GCD_DISPATCH_TIMEOUT_EN
      // engine never answers: timeout result, then normal operation with a stray late done ignored
      do_reset();
      eng_en = 1'b0; out_ready = 1'b1;
      push(32'd10, 32'd4, 32'd0, 4'd0, 1'b1);
      c0 = cyc;
      wait_valid(80, at);
      check("timeout_cycle", 32'(at), 32'(c0 + 2 + TIMEOUT));
      drain(10);
      eng_en = 1'b1;
      tick(); tick();
      eng_force = 1'b1;
      tick();
      eng_force = 1'b0;
      tick(); tick();
      check("late_done_ignored", 32'(out_valid), 32'd0);
      push(32'd10, 32'd4, 32'd2, 4'd1, 1'b0);
      drain(60);
`endif

      // reset while waiting on the engine with two pairs queued
      do_reset();
      eng_lat = 30; out_ready = 1'b1;
      push(32'd48, 32'd18, 32'd6, 4'd0, 1'b0);
      push(32'd0, 32'd5, 32'd5, 4'd1, 1'b0);
      push(32'd0, 32'd6, 32'd6, 4'd2, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      check("wait_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      check_rst("midreset");
      hits = 0;
      for (int i = 0; i < 45; i++) begin
         if (out_valid) hits++;
         tick();
      end
      check("stale_discarded", 32'(hits), 32'd0);
      push(32'd0, 32'd7, 32'd7, 4'd0, 1'b0);
      drain(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
